// File: rtl/blit_scheduler.sv
// blit_scheduler: queues CPU blit commands in a small FIFO and hands them to
// the blitter one at a time through an issue/run/release handshake.
// Optional feature macro BLIT_VSYNC_EN: adds a vblank input and holds
// CLEAR/SCROLL operations in WAIT_VB until vblank is seen.
module blit_scheduler #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [11:0] cmd_src,
  input  logic [3:0]  cmd_height,
  input  logic [6:0]  cmd_x,
  input  logic [5:0]  cmd_y,
  input  logic        flush,
  output logic [2:0]  blit_operation,
  output logic [11:0] blit_src,
  output logic [3:0]  blit_srcHeight,
  output logic [6:0]  blit_destX,
  output logic [5:0]  blit_destY,
  output logic        blit_enable,
  input  logic        blit_ready,
  input  logic        blit_collision,
`ifdef BLIT_VSYNC_EN
  input  logic        vblank,
`endif
  output logic        busy,
  output logic [4:0]  pending,
  output logic        done,
  output logic        collision_flag
);

  // Operation codes shared with the blitter (blitter.vh).
  localparam logic [2:0] BLIT_OP_SPRITE = 3'd4;
`ifdef BLIT_VSYNC_EN
  localparam logic [2:0] BLIT_OP_CLEAR        = 3'd0;
  localparam logic [2:0] BLIT_OP_SCROLL_LEFT  = 3'd1;
  localparam logic [2:0] BLIT_OP_SCROLL_RIGHT = 3'd2;
  localparam logic [2:0] BLIT_OP_SCROLL_DOWN  = 3'd3;
`endif

  localparam int         AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] FULL = 5'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef BLIT_VSYNC_EN
    S_WAIT_VB,
`endif
    S_ISSUE,
    S_RUN,
    S_RELEASE
  } state_t;

  state_t        state;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [4:0]    count;
  logic          ready_q;
  logic          push;
  logic          pop;
  logic [31:0]   head;

  // Command word layout: {op, src, height, x, y} = 3+12+4+7+6 bits.
  assign cmd_ready = (count != FULL);
  assign push      = cmd_valid && cmd_ready && !flush;
  assign head      = mem[rd_ptr];
  // Blitter must have been ready for two consecutive cycles so a blitter
  // still finishing a command dropped by reset is never re-driven early.
  assign pop       = (state == S_IDLE) && (count != 5'd0) && blit_ready && ready_q;
  assign busy      = (count != 5'd0) || (state != S_IDLE);
  assign pending   = count;

`ifdef BLIT_VSYNC_EN
  logic head_waits_vb;
  assign head_waits_vb = (head[31:29] == BLIT_OP_CLEAR)
                      || (head[31:29] == BLIT_OP_SCROLL_LEFT)
                      || (head[31:29] == BLIT_OP_SCROLL_RIGHT)
                      || (head[31:29] == BLIT_OP_SCROLL_DOWN);
`endif

  // Queue storage: write the packed command word at the write pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_op, cmd_src, cmd_height, cmd_x, cmd_y};
    end
  end

  // Queue pointers and occupancy; flush clears everything and beats a push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 5'd0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 5'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

  // Issue FSM with registered blitter operands, enable, done and collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      ready_q        <= 1'b0;
      blit_operation <= 3'd0;
      blit_src       <= 12'd0;
      blit_srcHeight <= 4'd0;
      blit_destX     <= 7'd0;
      blit_destY     <= 6'd0;
      blit_enable    <= 1'b0;
      done           <= 1'b0;
      collision_flag <= 1'b0;
    end else begin
      ready_q <= blit_ready;
      done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            {blit_operation, blit_src, blit_srcHeight, blit_destX, blit_destY} <= head;
`ifdef BLIT_VSYNC_EN
            if (head_waits_vb) begin
              state <= S_WAIT_VB;
            end else begin
              state       <= S_ISSUE;
              blit_enable <= 1'b1;
            end
`else
            state       <= S_ISSUE;
            blit_enable <= 1'b1;
`endif
          end
        end
`ifdef BLIT_VSYNC_EN
        S_WAIT_VB: begin
          if (vblank) begin
            state       <= S_ISSUE;
            blit_enable <= 1'b1;
          end
        end
`endif
        S_ISSUE: begin
          if (!blit_ready) state <= S_RUN;
        end
        S_RUN: begin
          if (blit_ready) begin
            state       <= S_RELEASE;
            blit_enable <= 1'b0;
            done        <= 1'b1;
            if (blit_operation == BLIT_OP_SPRITE) collision_flag <= blit_collision;
          end
        end
        S_RELEASE: begin
          state <= S_IDLE;
        end
        default: begin
          state       <= S_IDLE;
          blit_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blit_scheduler.sv
// tb_blit_scheduler: table-driven and hand-sequenced checks of blit_scheduler
// against a small blitter model and a scoreboard of issued commands.
module tb_blit_scheduler;

  localparam logic [2:0] OP_CLEAR  = 3'd0;
  localparam logic [2:0] OP_SLEFT  = 3'd1;
  localparam logic [2:0] OP_SRIGHT = 3'd2;
  localparam logic [2:0] OP_SDOWN  = 3'd3;
  localparam logic [2:0] OP_SPRITE = 3'd4;

  typedef struct {
    logic [2:0]  op;
    logic [11:0] src;
    logic [3:0]  h;
    logic [6:0]  x;
    logic [5:0]  y;
    logic        coll;
    logic        exp_coll;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [11:0] cmd_src = 12'd0;
  logic [3:0]  cmd_height = 4'd0;
  logic [6:0]  cmd_x = 7'd0;
  logic [5:0]  cmd_y = 6'd0;
  logic        flush = 1'b0;
  logic [2:0]  blit_operation;
  logic [11:0] blit_src;
  logic [3:0]  blit_srcHeight;
  logic [6:0]  blit_destX;
  logic [5:0]  blit_destY;
  logic        blit_enable;
  logic        blit_ready;
  logic        blit_collision;
  logic        busy;
  logic [4:0]  pending;
  logic        done;
  logic        collision_flag;
`ifdef BLIT_VSYNC_EN
  logic        vblank = 1'b1;
`endif

  int total = 0;
  int bad   = 0;

  blit_scheduler #(.DEPTH(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_src(cmd_src),
    .cmd_height(cmd_height),
    .cmd_x(cmd_x),
    .cmd_y(cmd_y),
    .flush(flush),
    .blit_operation(blit_operation),
    .blit_src(blit_src),
    .blit_srcHeight(blit_srcHeight),
    .blit_destX(blit_destX),
    .blit_destY(blit_destY),
    .blit_enable(blit_enable),
    .blit_ready(blit_ready),
    .blit_collision(blit_collision),
`ifdef BLIT_VSYNC_EN
    .vblank(vblank),
`endif
    .busy(busy),
    .pending(pending),
    .done(done),
    .collision_flag(collision_flag)
  );

  always #5 clk = ~clk;

  // Blitter model: drops ready after seeing enable, stays busy busy_len
  // cycles, then raises ready with its collision result until enable drops.
  int   busy_len = 4;
  logic stall = 1'b0;
  logic model_ready = 1'b1;
  logic model_coll = 1'b0;
  logic next_coll;
  int   mstate = 0;
  int   mcnt = 0;
  logic coll_q[$];

  assign blit_ready     = stall ? 1'b0 : model_ready;
  assign blit_collision = model_coll;

  always @(posedge clk) begin
    case (mstate)
      0: if (blit_enable) begin
        next_coll = (coll_q.size() > 0) ? coll_q.pop_front() : 1'b0;
        model_coll  <= next_coll;
        model_ready <= 1'b0;
        mcnt        <= busy_len;
        mstate      <= 1;
      end
      1: if (mcnt <= 1) begin
        model_ready <= 1'b1;
        mstate      <= 2;
      end else begin
        mcnt <= mcnt - 1;
      end
      default: if (!blit_enable) mstate <= 0;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic failNow(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Scoreboard monitor: pops the expected command on each enable rise and
  // checks operands stay fixed and the flag is right when done pulses.
  vec_t sb[$];
  vec_t cur;
  logic inflight = 1'b0;
  logic prev_en = 1'b0;
  logic prev_done = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      inflight  = 1'b0;
      prev_en   = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (blit_enable && !prev_en) begin
        if (sb.size() == 0) begin
          failNow("unexpected_issue");
        end else begin
          cur      = sb.pop_front();
          inflight = 1'b1;
        end
      end
      if (inflight) begin
        checkOutput("op_stable", 32'(blit_operation), 32'(cur.op));
        checkOutput("src_stable", 32'(blit_src), 32'(cur.src));
        checkOutput("height_stable", 32'(blit_srcHeight), 32'(cur.h));
        checkOutput("x_stable", 32'(blit_destX), 32'(cur.x));
        checkOutput("y_stable", 32'(blit_destY), 32'(cur.y));
      end
      if (done) begin
        checkOutput("done_single", 32'(prev_done), 32'd0);
        if (inflight) checkOutput("flag_at_done", 32'(collision_flag), 32'(cur.exp_coll));
        else failNow("done_without_issue");
        inflight = 1'b0;
      end
      prev_en   = blit_enable;
      prev_done = done;
    end
  end

  task automatic driveCmd(input vec_t v);
    cmd_op     = v.op;
    cmd_src    = v.src;
    cmd_height = v.h;
    cmd_x      = v.x;
    cmd_y      = v.y;
  endtask

  task automatic waitDone(input string name, input int limit);
    bit got;
    got = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) failNow(name);
  endtask

  task automatic waitRun(input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (blit_enable && !blit_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) failNow(name);
    @(negedge clk);
  endtask

  // One isolated command: push, check issue latency, wait for completion.
  task automatic applyStimulus(input vec_t v);
    int lat;
    lat = 1;
`ifdef BLIT_VSYNC_EN
    if (v.op != OP_SPRITE) lat = 2;
`endif
    @(negedge clk);
    driveCmd(v);
    cmd_valid = 1'b1;
    checkOutput("vec_ready", 32'(cmd_ready), 32'd1);
    sb.push_back(v);
    coll_q.push_back(v.coll);
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("vec_pending", 32'(pending), 32'd1);
    checkOutput("vec_en_early", 32'(blit_enable), 32'd0);
    repeat (lat) @(negedge clk);
    checkOutput("vec_en_latency", 32'(blit_enable), 32'd1);
    waitDone("vec_done", 100);
    @(negedge clk);
    checkOutput("vec_done_low", 32'(done), 32'd0);
    checkOutput("vec_busy_after", 32'(busy), 32'd0);
    checkOutput("vec_flag_after", 32'(collision_flag), 32'(v.exp_coll));
  endtask

  vec_t vecs[8];
  vec_t fill[5];
  vec_t c1, c2, c3, c4, x1, x2;

  initial begin
    vecs[0] = '{OP_SPRITE, 12'h200, 4'd5,  7'd10,  6'd3,  1'b1, 1'b1};
    vecs[1] = '{OP_CLEAR,  12'h000, 4'd0,  7'd0,   6'd0,  1'b0, 1'b1};
    vecs[2] = '{OP_SLEFT,  12'h010, 4'd2,  7'd4,   6'd0,  1'b1, 1'b1};
    vecs[3] = '{OP_SPRITE, 12'hABC, 4'd15, 7'd127, 6'd63, 1'b0, 1'b0};
    vecs[4] = '{OP_SDOWN,  12'h000, 4'd0,  7'd0,   6'd63, 1'b1, 1'b0};
    vecs[5] = '{OP_SPRITE, 12'hFFF, 4'd0,  7'd0,   6'd0,  1'b1, 1'b1};
    vecs[6] = '{OP_SRIGHT, 12'h123, 4'd7,  7'd64,  6'd32, 1'b0, 1'b1};
    vecs[7] = '{OP_SPRITE, 12'h001, 4'd1,  7'd1,   6'd1,  1'b0, 1'b0};

    fill[0] = '{OP_SPRITE, 12'h111, 4'd1, 7'd11, 6'd1, 1'b0, 1'b0};
    fill[1] = '{OP_CLEAR,  12'h222, 4'd2, 7'd22, 6'd2, 1'b1, 1'b0};
    fill[2] = '{OP_SPRITE, 12'h333, 4'd3, 7'd33, 6'd3, 1'b1, 1'b1};
    fill[3] = '{OP_SRIGHT, 12'h444, 4'd4, 7'd44, 6'd4, 1'b0, 1'b1};
    fill[4] = '{OP_SPRITE, 12'h555, 4'd5, 7'd55, 6'd5, 1'b0, 1'b0};

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_pending", 32'(pending), 32'd0);
    checkOutput("rst_enable", 32'(blit_enable), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_flag", 32'(collision_flag), 32'd0);
    checkOutput("rst_operands", {blit_operation, blit_src, blit_srcHeight, blit_destX, blit_destY}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Table-driven single commands, including the collision-flag history.
    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    // Fill the queue against a stalled blitter; the fifth push is dropped.
    @(negedge clk);
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      driveCmd(fill[k]);
      cmd_valid = 1'b1;
      checkOutput("fill_ready", 32'(cmd_ready), (k < 4) ? 32'd1 : 32'd0);
      if (k < 4) begin
        sb.push_back(fill[k]);
        coll_q.push_back(fill[k].coll);
      end
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("full_pending", 32'(pending), 32'd4);
    checkOutput("full_ready_low", 32'(cmd_ready), 32'd0);
    checkOutput("full_no_issue", 32'(blit_enable), 32'd0);
    checkOutput("full_busy", 32'(busy), 32'd1);
    stall = 1'b0;
    for (int k = 0; k < 4; k++) waitDone("drain_done", 100);
    @(negedge clk);
    checkOutput("drain_pending", 32'(pending), 32'd0);
    checkOutput("drain_busy", 32'(busy), 32'd0);
    checkOutput("drain_flag", 32'(collision_flag), 32'd1);

    // Flush while the first of three commands runs; push on the flush edge.
    busy_len = 8;
    c1 = '{OP_SPRITE, 12'h0A1, 4'd3, 7'd5, 6'd7, 1'b0, 1'b0};
    c2 = '{OP_CLEAR,  12'h0A2, 4'd0, 7'd0, 6'd0, 1'b0, 1'b0};
    c3 = '{OP_SPRITE, 12'h0A3, 4'd1, 7'd2, 6'd3, 1'b1, 1'b1};
    c4 = '{OP_SPRITE, 12'h0A4, 4'd2, 7'd3, 6'd4, 1'b1, 1'b1};
    @(negedge clk);
    driveCmd(c1); cmd_valid = 1'b1;
    sb.push_back(c1); coll_q.push_back(c1.coll);
    @(negedge clk);
    checkOutput("seq_pending1", 32'(pending), 32'd1);
    driveCmd(c2);
    sb.push_back(c2); coll_q.push_back(c2.coll);
    @(negedge clk);
    checkOutput("pushpop_pending", 32'(pending), 32'd1);
    checkOutput("seq_enable", 32'(blit_enable), 32'd1);
    driveCmd(c3);
    sb.push_back(c3); coll_q.push_back(c3.coll);
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("seq_pending2", 32'(pending), 32'd2);
    waitRun("flush_wait_run");
    driveCmd(c4); cmd_valid = 1'b1; flush = 1'b1;
    sb.delete();
    coll_q.delete();
    @(negedge clk);
    cmd_valid = 1'b0; flush = 1'b0;
    checkOutput("flush_pending", 32'(pending), 32'd0);
    checkOutput("flush_ready", 32'(cmd_ready), 32'd1);
    checkOutput("flush_busy", 32'(busy), 32'd1);
    checkOutput("flush_inflight", 32'(blit_enable), 32'd1);
    waitDone("flush_done", 60);
    checkOutput("release_busy", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("flush_busy_low", 32'(busy), 32'd0);
    begin
      int en_cnt;
      en_cnt = 0;
      repeat (10) begin
        @(negedge clk);
        if (blit_enable) en_cnt++;
      end
      checkOutput("flush_no_reissue", 32'(en_cnt), 32'd0);
    end

    // Reset during RUN while the blitter keeps working; re-issue must wait
    // for two consecutive ready cycles.
    busy_len = 12;
    x1 = '{OP_SPRITE, 12'h0B1, 4'd4, 7'd8, 6'd9, 1'b1, 1'b1};
    x2 = '{OP_SPRITE, 12'h0B2, 4'd6, 7'd12, 6'd13, 1'b1, 1'b1};
    @(negedge clk);
    driveCmd(x1); cmd_valid = 1'b1;
    sb.push_back(x1); coll_q.push_back(x1.coll);
    @(negedge clk);
    cmd_valid = 1'b0;
    waitRun("reset_wait_run");
    rst_n = 1'b0;
    sb.delete();
    coll_q.delete();
    @(negedge clk);
    checkOutput("midrst_enable", 32'(blit_enable), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_flag", 32'(collision_flag), 32'd0);
    checkOutput("midrst_ready", 32'(cmd_ready), 32'd1);
    rst_n = 1'b1;
    driveCmd(x2); cmd_valid = 1'b1;
    sb.push_back(x2); coll_q.push_back(x2.coll);
    @(negedge clk);
    cmd_valid = 1'b0;
    begin
      int hc;
      bit got;
      bit seen_low;
      hc = 0; got = 1'b0; seen_low = 1'b0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (blit_enable) begin
          checkOutput("reissue_ready_cycles", 32'(hc), 32'd2);
          got = 1'b1;
          break;
        end
        if (blit_ready) hc++;
        else begin
          hc = 0;
          seen_low = 1'b1;
        end
      end
      if (!got) failNow("reissue_timeout");
      checkOutput("reissue_saw_busy_blitter", 32'(seen_low), 32'd1);
    end
    waitDone("reissue_done", 60);
    @(negedge clk);
    checkOutput("reissue_flag", 32'(collision_flag), 32'd1);

`ifdef BLIT_VSYNC_EN
    // Scroll held until vblank, then issued on the following cycle.
    busy_len = 3;
    vblank = 1'b0;
    begin
      vec_t s;
      int en_cnt;
      s = '{OP_SLEFT, 12'h0C0, 4'd0, 7'd1, 6'd0, 1'b0, 1'b1};
      @(negedge clk);
      driveCmd(s); cmd_valid = 1'b1;
      sb.push_back(s); coll_q.push_back(s.coll);
      @(negedge clk);
      cmd_valid = 1'b0;
      en_cnt = 0;
      repeat (20) begin
        @(negedge clk);
        if (blit_enable) en_cnt++;
      end
      checkOutput("vb_hold", 32'(en_cnt), 32'd0);
      checkOutput("vb_busy", 32'(busy), 32'd1);
      vblank = 1'b1;
      @(negedge clk);
      vblank = 1'b0;
      checkOutput("vb_issue", 32'(blit_enable), 32'd1);
      waitDone("vb_done", 60);
      vblank = 1'b1;
    end
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
